// File: rtl/clk_div_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// clk_div_arbiter_pkg
// Shared state encoding, counter width and default ratio for clk_div_arbiter.
// Rev 1.0
// ============================================================================
package clk_div_arbiter_pkg;

  // Width of the reset/settle cycle counter; RST_CYC and SET_CYC must fit.
  localparam int CNT_W = 4;

  // Ratio driven to the divider while nobody owns it.
  localparam logic [7:0] DEF_DIV_INIT = 8'd1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD     = 3'd1;
  localparam state_t ST_SETTLE   = 3'd2;
  localparam state_t ST_OWNED    = 3'd3;
  localparam state_t ST_PARK     = 3'd4;
  localparam state_t ST_PARK_SET = 3'd5;

  // True in the states where a requester holds the divider.
  function automatic logic is_owning(input state_t s);
    return (s == ST_LOAD) || (s == ST_SETTLE) || (s == ST_OWNED);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_arbiter_rr_arb.sv
`default_nettype none
// ============================================================================
// clk_div_arbiter_rr_arb
// Combinational round-robin pick: first asserted request at or after ptr,
// searching cyclically. Returns a one-hot grant, its index and a valid flag.
// Rev 1.0
// ============================================================================
module clk_div_arbiter_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  // Walk the requesters starting at the pointer and keep the first hit.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDW + 1)'(i);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      cand = sum[IDW-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_arbiter.sv
`default_nettype none
// ============================================================================
// clk_div_arbiter
// Shares one programmable clock divider among NREQ requesters. A round-robin
// winner owns the divider; its ratio is applied through a reset-load-settle
// sequence, and on release the divider is parked back at DEF_DIV.
// Rev 1.0
// ============================================================================
module clk_div_arbiter
  import clk_div_arbiter_pkg::*;
#(
  parameter int         NREQ    = 4,
  parameter int         RST_CYC = 2,
  parameter int         SET_CYC = 4,
  parameter logic [7:0] DEF_DIV = DEF_DIV_INIT
) (
  input  logic              origin_clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_div,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ready,
  output logic [7:0]        div,
  output logic              div_rst_n,
  output logic              busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SET_CYC - 1);
  localparam logic [IDW-1:0]   LAST_ID  = IDW'(NREQ - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDW-1:0]   id;
  logic [IDW-1:0]   id_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic [7:0]       ratio;
  logic [7:0]       ratio_nxt;

  logic [NREQ-1:0]  grant_nxt;
  logic [NREQ-1:0]  ready_nxt;
  logic [7:0]       div_nxt;
  logic             div_rst_n_nxt;
  logic             busy_nxt;

  logic [NREQ-1:0]  pick_gnt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;

  logic             owner_req;
  logic             rst_done;
  logic             set_done;

  assign owner_req = req[id];
  assign rst_done  = (cnt == RST_LAST);
  assign set_done  = (cnt == SET_LAST);

  clk_div_arbiter_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arb (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // State, counter, latched owner and all outputs; every output is registered.
  always_ff @(posedge origin_clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      id        <= '0;
      ptr       <= '0;
      ratio     <= DEF_DIV;
      grant     <= '0;
      ready     <= '0;
      div       <= DEF_DIV;
      div_rst_n <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      id        <= id_nxt;
      ptr       <= ptr_nxt;
      ratio     <= ratio_nxt;
      grant     <= grant_nxt;
      ready     <= ready_nxt;
      div       <= div_nxt;
      div_rst_n <= div_rst_n_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next state: a release by the owner wins over any sequence progress.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_any) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (!owner_req)    state_nxt = ST_PARK;
        else if (rst_done) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!owner_req)    state_nxt = ST_PARK;
        else if (set_done) state_nxt = ST_OWNED;
      end
      ST_OWNED: begin
        if (!owner_req) state_nxt = ST_PARK;
      end
      ST_PARK: begin
        if (rst_done) state_nxt = ST_PARK_SET;
      end
      ST_PARK_SET: begin
        if (set_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Values the output registers take next, derived from the upcoming state
  // so the outputs always agree with the state they are registered alongside.
  always_comb begin
    id_nxt    = id;
    ratio_nxt = ratio;
    ptr_nxt   = ptr;
    if ((state == ST_IDLE) && pick_any) begin
      id_nxt    = pick_idx;
      ratio_nxt = req_div[{pick_idx, 3'b000} +: 8];
    end
    // The releasing owner gets lowest priority in the next arbitration.
    if (is_owning(state) && (state_nxt == ST_PARK)) begin
      ptr_nxt = (id == LAST_ID) ? '0 : id + IDW'(1);
    end
    grant_nxt     = is_owning(state_nxt) ? (NREQ'(1) << id_nxt) : '0;
    ready_nxt     = (state_nxt == ST_OWNED) ? (NREQ'(1) << id_nxt) : '0;
    div_nxt       = is_owning(state_nxt) ? ratio_nxt : DEF_DIV;
    div_rst_n_nxt = !((state_nxt == ST_LOAD) || (state_nxt == ST_PARK));
    busy_nxt      = (state_nxt != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_arbiter.sv
`default_nettype none
// ============================================================================
// tb_clk_div_arbiter
// Scoreboard bench: expected owner/ratio pushed when requests are driven,
// popped and compared when ready appears.
// Rev 1.0
// ============================================================================
module tb_clk_div_arbiter;

  localparam int         NREQ    = 4;
  localparam int         RST_CYC = 2;
  localparam int         SET_CYC = 4;
  localparam logic [7:0] DEF_DIV = 8'd1;
  localparam int         LIMIT   = 50;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_div = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ready;
  logic [7:0]        div;
  logic              div_rst_n;
  logic              busy;

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [7:0]      d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  clk_div_arbiter #(
    .NREQ    (NREQ),
    .RST_CYC (RST_CYC),
    .SET_CYC (SET_CYC),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .origin_clk (clk),
    .reset      (rst_n),
    .req        (req),
    .req_div    (req_div),
    .grant      (grant),
    .ready      (ready),
    .div        (div),
    .div_rst_n  (div_rst_n),
    .busy       (busy)
  );

  // Reference divider: toggles every div+1 cycles, period 2*(div+1).
  logic [7:0] dcnt;
  logic       div_clk;
  always @(posedge clk or negedge div_rst_n or negedge rst_n) begin
    if (!div_rst_n || !rst_n) begin
      dcnt    <= '0;
      div_clk <= 1'b0;
    end else if (dcnt == div) begin
      dcnt    <= '0;
      div_clk <= ~div_clk;
    end else begin
      dcnt <= dcnt + 8'd1;
    end
  end

  // Structural invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (!$onehot0(grant) || !$onehot0(ready) || ((ready & ~grant) != '0) ||
          ((ready != '0) && !div_rst_n)) begin
        n_fail++;
        $display("FAIL invariant: grant=%b ready=%b div_rst_n=%b", grant, ready, div_rst_n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n, output int low);
    n   = 0;
    low = 0;
    do begin
      tick();
      n++;
      if (!div_rst_n) low++;
    end while ((ready == '0) && (n < LIMIT));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while ((busy !== 1'b0) && (n < LIMIT)) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (div !== DEF_DIV) begin n_fail++; $display("FAIL reset_div: got %0d want %0d", div, DEF_DIV); end
    n_cmp++; if (div_rst_n !== 1'b1) begin n_fail++; $display("FAIL reset_div_rst_n: got %b want 1", div_rst_n); end
    n_cmp++; if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_cmp++; if (ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (4) tick();
    n_cmp++; if (busy !== 1'b0 || grant !== '0) begin n_fail++; $display("FAIL idle_no_req: busy=%b grant=%b want 0/0000", busy, grant); end
  endtask

  task automatic test_single();
    int   n, low, first, second, w;
    logic prev;
    exp_t e;
    req_div[7:0] = 8'd5;
    req          = 4'b0001;
    sb.push_back('{g: 4'b0001, d: 8'd5});
    wait_ready(n, low);
    n_cmp++; if (n != 1 + RST_CYC + SET_CYC) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", n, 1 + RST_CYC + SET_CYC); end
    n_cmp++; if (low != RST_CYC) begin n_fail++; $display("FAIL single_rst_low: got %0d want %0d", low, RST_CYC); end
    if (sb.size() == 0) begin
      n_cmp++; n_fail++; $display("FAIL single_sb: got empty want entry");
    end else begin
      e = sb.pop_front();
      n_cmp++; if (ready !== e.g) begin n_fail++; $display("FAIL single_ready: got %b want %b", ready, e.g); end
      n_cmp++; if (grant !== e.g) begin n_fail++; $display("FAIL single_grant: got %b want %b", grant, e.g); end
      n_cmp++; if (div !== e.d) begin n_fail++; $display("FAIL single_div: got %0d want %0d", div, e.d); end
    end
    first  = -1;
    second = -1;
    prev   = div_clk;
    for (int k = 0; k < 60 && second < 0; k++) begin
      tick();
      if (div_clk && !prev) begin
        if (first < 0) first = k;
        else second = k;
      end
      prev = div_clk;
    end
    n_cmp++; if (second - first != 12) begin n_fail++; $display("FAIL single_period: got %0d want 12", second - first); end
    req = 4'b0000;
    tick();
    n_cmp++; if (div !== DEF_DIV || div_rst_n !== 1'b0 || grant !== '0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_park: div=%0d rst_n=%b grant=%b busy=%b want %0d/0/0000/1", div, div_rst_n, grant, busy, DEF_DIV);
    end
    wait_idle(w);
    n_cmp++; if (w >= LIMIT) begin n_fail++; $display("FAIL single_idle_timeout: got %0d want <%0d", w, LIMIT); end
  endtask

  task automatic test_round_robin();
    int   n, low, w;
    exp_t e;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req_div = {8'd5, 8'd4, 8'd3, 8'd2};
    sb.push_back('{g: 4'b0001, d: 8'd2});
    sb.push_back('{g: 4'b0010, d: 8'd3});
    sb.push_back('{g: 4'b0100, d: 8'd4});
    sb.push_back('{g: 4'b1000, d: 8'd5});
    sb.push_back('{g: 4'b0001, d: 8'd2});
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_ready(n, low);
      if (sb.size() == 0) begin
        n_cmp++; n_fail++; $display("FAIL rr_sb: got empty want entry");
      end else begin
        e = sb.pop_front();
        n_cmp++; if (grant !== e.g || ready !== e.g) begin n_fail++; $display("FAIL rr_grant%0d: got %b/%b want %b", r, grant, ready, e.g); end
        n_cmp++; if (div !== e.d) begin n_fail++; $display("FAIL rr_div%0d: got %0d want %0d", r, div, e.d); end
        repeat (10) tick();
        for (int b = 0; b < NREQ; b++) if (e.g[b]) req[b] = 1'b0;
        tick();
        if (r == 0) req[0] = 1'b1;
      end
    end
    req = '0;
    wait_idle(w);
    n_cmp++; if (w >= LIMIT) begin n_fail++; $display("FAIL rr_idle_timeout: got %0d want <%0d", w, LIMIT); end
  endtask

  task automatic test_abort();
    int   n, low, w, seen;
    exp_t e;
    seen = 0;
    req_div[23:16] = 8'd7;
    req = 4'b0100;
    repeat (RST_CYC + 1) begin
      tick();
      if (ready != '0) seen++;
    end
    n_cmp++; if (grant !== 4'b0100 || div_rst_n !== 1'b1 || ready !== '0) begin
      n_fail++; $display("FAIL abort_settle: grant=%b rst_n=%b ready=%b want 0100/1/0000", grant, div_rst_n, ready);
    end
    req_div[31:24] = 8'd6;
    req_div[7:0]   = 8'd3;
    req = 4'b1001;
    sb.push_back('{g: 4'b1000, d: 8'd6});
    tick();
    n_cmp++; if (grant !== '0 || ready !== '0 || div !== DEF_DIV || div_rst_n !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_park: grant=%b ready=%b div=%0d rst_n=%b busy=%b", grant, ready, div, div_rst_n, busy);
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL abort_ready_seen: got %0d want 0", seen); end
    wait_ready(n, low);
    if (sb.size() == 0) begin
      n_cmp++; n_fail++; $display("FAIL abort_sb: got empty want entry");
    end else begin
      e = sb.pop_front();
      n_cmp++; if (grant !== e.g || ready !== e.g) begin n_fail++; $display("FAIL abort_next_grant: got %b/%b want %b", grant, ready, e.g); end
      n_cmp++; if (div !== e.d) begin n_fail++; $display("FAIL abort_next_div: got %0d want %0d", div, e.d); end
    end
    req = '0;
    tick();
    wait_idle(w);
  endtask

  task automatic test_ratio_change();
    int   n, low, w;
    exp_t e;
    req_div[15:8] = 8'd5;
    req = 4'b0010;
    sb.push_back('{g: 4'b0010, d: 8'd5});
    wait_ready(n, low);
    e = sb.pop_front();
    n_cmp++; if (ready !== e.g || div !== e.d) begin n_fail++; $display("FAIL ratio_first: ready=%b div=%0d want %b/%0d", ready, div, e.g, e.d); end
    req_div[15:8] = 8'd9;
    repeat (5) tick();
    n_cmp++; if (div !== 8'd5 || ready !== 4'b0010) begin n_fail++; $display("FAIL ratio_hold: div=%0d ready=%b want 5/0010", div, ready); end
    req = '0;
    tick();
    wait_idle(w);
    req = 4'b0010;
    sb.push_back('{g: 4'b0010, d: 8'd9});
    wait_ready(n, low);
    e = sb.pop_front();
    n_cmp++; if (ready !== e.g || div !== e.d) begin n_fail++; $display("FAIL ratio_second: ready=%b div=%0d want %b/%0d", ready, div, e.g, e.d); end
    req = '0;
    tick();
    wait_idle(w);
  endtask

  task automatic test_reset_mid();
    int   n, low;
    exp_t e;
    req = 4'b0110;
    tick();
    n_cmp++; if (grant !== 4'b0100 || div !== 8'd7 || div_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL mid_load: grant=%b div=%0d rst_n=%b want 0100/7/0", grant, div, div_rst_n);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (grant !== '0 || ready !== '0 || div !== DEF_DIV || div_rst_n !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: grant=%b ready=%b div=%0d rst_n=%b busy=%b", grant, ready, div, div_rst_n, busy);
    end
    tick();
    tick();
    sb.push_back('{g: 4'b0010, d: 8'd9});
    rst_n = 1'b1;
    wait_ready(n, low);
    e = sb.pop_front();
    n_cmp++; if (grant !== e.g || div !== e.d) begin n_fail++; $display("FAIL mid_rearb: grant=%b div=%0d want %b/%0d", grant, div, e.g, e.d); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_ratio_change();
    test_reset_mid();
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
